// File: rtl/systolic_tile_controller.sv
// systolic_tile_controller: multi-tile weight-stationary systolic array sequencer
// Ports: clk/rst (async active-high); start/abort/cfg_* job control from scheduler;
//        wt_valid/wt_ready weight handshake, sys_wt_en weight shift;
//        in_valid/sys_en/rd_addr activation stream; we/acc_en/wr_addr output buffer;
//        tile_idx, ready, busy, done, err status.
module systolic_tile_controller #(
    parameter int N_SIZE = 32,
    parameter int MAX_ROWS = 512,
    parameter int MAX_TILES = 16,
    parameter int ADDR_WIDTH = 10,
    localparam int ROW_W = $clog2(MAX_ROWS + 1),
    localparam int TILE_W = $clog2(MAX_TILES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ROW_W-1:0]      cfg_rows,
    input  logic [TILE_W-1:0]     cfg_tiles,
    input  logic                  cfg_accum,
    input  logic                  wt_valid,
    output logic                  wt_ready,
    input  logic                  in_valid,
    output logic                  sys_wt_en,
    output logic                  sys_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  we,
    output logic                  acc_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [TILE_W-1:0]     tile_idx,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int LAT = 2 * N_SIZE - 2;
    localparam int K_W = $clog2(MAX_ROWS + LAT + 1);
    localparam int B_W = $clog2(N_SIZE + 1);
    typedef enum logic [1:0] {IDLE, LOAD_WT, COMPUTE, DONE} state_t;
    state_t state, state_n;
    logic [B_W-1:0] beat;
    logic [K_W-1:0] k;
    logic [ROW_W-1:0] rows;
    logic [TILE_W-1:0] tiles;
    logic accum;
    logic [ADDR_WIDTH-1:0] wr_base;
    logic comp, cfg_bad, go, feeding, last_beat, last_step, last_tile, kill;
    assign comp = state == COMPUTE;
    assign cfg_bad = cfg_rows == '0 || cfg_rows > ROW_W'(MAX_ROWS) || cfg_tiles == '0 || cfg_tiles > TILE_W'(MAX_TILES);
    assign go = state == IDLE && start && !cfg_bad;
    assign kill = abort && state != IDLE;
    // k below rows: feeding activations; at or above rows: draining the array pipeline
    assign feeding = k < K_W'(rows);
    assign ready = state == IDLE;
    assign busy = !ready;
    assign wt_ready = state == LOAD_WT;
    assign sys_wt_en = wt_ready && wt_valid;
    assign sys_en = comp && (feeding ? in_valid : 1'b1);
    assign we = sys_en && k >= K_W'(LAT);
    assign acc_en = we && accum && tile_idx != '0;
    assign rd_addr = !comp ? '0 : feeding ? ADDR_WIDTH'(k) : ADDR_WIDTH'(rows - ROW_W'(1));
    assign wr_addr = comp ? wr_base + ADDR_WIDTH'(k - K_W'(LAT)) : '0;
    assign last_beat = sys_wt_en && beat == B_W'(N_SIZE - 1);
    assign last_step = sys_en && k == K_W'(rows) + K_W'(LAT - 1);
    assign last_tile = tile_idx == tiles - TILE_W'(1);
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = go ? LOAD_WT : IDLE;
            LOAD_WT: state_n = last_beat ? COMPUTE : LOAD_WT;
            COMPUTE: state_n = !last_step ? COMPUTE : last_tile ? DONE : LOAD_WT;
            default: state_n = IDLE;
        endcase
        if (kill)
            state_n = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat <= '0;
            k <= '0;
            rows <= '0;
            tiles <= '0;
            accum <= 1'b0;
            tile_idx <= '0;
            wr_base <= '0;
            err <= 1'b0;
            done <= 1'b0;
        end else begin
            err <= state == IDLE && start && cfg_bad;
            // DONE is only ever entered for one cycle, so this is a single-cycle pulse
            done <= state_n == DONE;
            if (kill) begin
                beat <= '0;
                k <= '0;
                tile_idx <= '0;
                wr_base <= '0;
            end else begin
                if (go) begin
                    rows <= cfg_rows;
                    tiles <= cfg_tiles;
                    accum <= cfg_accum;
                    tile_idx <= '0;
                    wr_base <= '0;
                    beat <= '0;
                    k <= '0;
                end
                if (sys_wt_en)
                    beat <= last_beat ? '0 : beat + B_W'(1);
                if (sys_en)
                    k <= last_step ? '0 : k + K_W'(1);
                if (last_step && !last_tile) begin
                    tile_idx <= tile_idx + TILE_W'(1);
                    wr_base <= accum ? wr_base : wr_base + ADDR_WIDTH'(rows);
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_tile_controller.sv
// tb_systolic_tile_controller: directed self-checking bench for systolic_tile_controller (N_SIZE=4)
module tb_systolic_tile_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, cfg_accum = 1'b0, wt_valid = 1'b0, in_valid = 1'b0;
    logic [9:0] cfg_rows = '0;
    logic [4:0] cfg_tiles = '0;
    logic wt_ready, sys_wt_en, sys_en, we, acc_en, ready, busy, done, err;
    logic [9:0] rd_addr, wr_addr;
    logic [4:0] tile_idx;
    int checks = 0, failures = 0;
    logic r_sys_en [0:600];
    logic r_ready [0:600];
    logic [9:0] r_rd [0:600];
    logic [4:0] r_tile [0:600];
    logic [9:0] wq[$];
    logic aq[$];
    logic [4:0] tq[$];
    logic [9:0] rq[$];
    int wt_pulses, done_cnt, done_cyc, end_cyc, first_we;

    systolic_tile_controller #(.N_SIZE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_rows(cfg_rows),
        .cfg_tiles(cfg_tiles), .cfg_accum(cfg_accum), .wt_valid(wt_valid), .wt_ready(wt_ready),
        .in_valid(in_valid), .sys_wt_en(sys_wt_en), .sys_en(sys_en), .rd_addr(rd_addr),
        .we(we), .acc_en(acc_en), .wr_addr(wr_addr), .tile_idx(tile_idx), .ready(ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Called at a negedge with the DUT idle; start is sampled at the next edge (edge 0).
    // Cycle c is the interval after edge c-1; gaps/abort/start are given as cycle numbers.
    task automatic run_job(input int rows, tiles, accum, wgc, wgn, igc, ign, ac, sc);
        int en_cnt;
        en_cnt = 0;
        wt_pulses = 0; done_cnt = 0; done_cyc = 0; end_cyc = 0; first_we = 0;
        wq.delete(); aq.delete(); tq.delete(); rq.delete();
        cfg_rows = 10'(rows); cfg_tiles = 5'(tiles); cfg_accum = accum[0];
        start = 1'b1; wt_valid = 1'b1; in_valid = 1'b1; abort = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= 600; c++) begin
            wt_valid = !(c >= wgc && c < wgc + wgn);
            in_valid = !(c >= igc && c < igc + ign);
            abort = (c == ac);
            start = (c == sc);
            @(negedge clk);
            r_sys_en[c] = sys_en; r_ready[c] = ready; r_rd[c] = rd_addr; r_tile[c] = tile_idx;
            if (sys_wt_en) wt_pulses++;
            if (sys_en) begin
                if (en_cnt < rows) rq.push_back(rd_addr);
                en_cnt++;
            end
            if (we) begin
                wq.push_back(wr_addr); aq.push_back(acc_en); tq.push_back(tile_idx);
                if (first_we == 0) first_we = c;
            end
            if (done) begin done_cnt++; done_cyc = c; end
            if (ready) begin end_cyc = c; break; end
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; wt_valid = 1'b0; in_valid = 1'b0;
        if (end_cyc == 0) begin failures++; $display("FAIL job_timeout got=no_idle exp=idle_within_600"); end
        checks++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++;
        if ({wt_ready, sys_wt_en, sys_en, we, acc_en, busy, done, err} !== 8'h00) begin failures++; $display("FAIL reset_flags got=%b exp=00000000", {wt_ready, sys_wt_en, sys_en, we, acc_en, busy, done, err}); end
        checks++;
        if ({rd_addr, wr_addr, tile_idx} !== 25'h0) begin failures++; $display("FAIL reset_addrs got=%h/%h/%h exp=0", rd_addr, wr_addr, tile_idx); end
        checks++;
    endtask

    task automatic test_err;
        int rv [3] = '{0, 600, 8};
        int tv [3] = '{1, 1, 17};
        for (int i = 0; i < 3; i++) begin
            cfg_rows = 10'(rv[i]); cfg_tiles = 5'(tv[i]); start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            if (err !== 1'b1 || ready !== 1'b1) begin failures++; $display("FAIL err_pulse[%0d] got=err%b_ready%b exp=err1_ready1", i, err, ready); end
            checks++;
            @(negedge clk);
            if (err !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL err_clear[%0d] got=err%b_ready%b exp=err0_ready1", i, err, ready); end
            checks++;
        end
    endtask

    task automatic test_single;
        run_job(8, 1, 0, 0, 0, 0, 0, 0, 0);
        if (wt_pulses !== 4) begin failures++; $display("FAIL single_wt_pulses got=%0d exp=4", wt_pulses); end
        checks++;
        if (done_cyc !== 19 || done_cnt !== 1) begin failures++; $display("FAIL single_done got=cyc%0d_cnt%0d exp=cyc19_cnt1", done_cyc, done_cnt); end
        checks++;
        if (first_we !== 11) begin failures++; $display("FAIL single_first_we got=%0d exp=11", first_we); end
        checks++;
        if (r_ready[5] !== 1'b0) begin failures++; $display("FAIL single_busy got=ready%b exp=ready0", r_ready[5]); end
        checks++;
        if (wq.size() !== 8 || rq.size() !== 8) begin failures++; $display("FAIL single_counts got=wr%0d_rd%0d exp=8_8", wq.size(), rq.size()); end
        checks++;
        for (int i = 0; i < 8; i++) begin
            if (rq[i] !== 10'(i)) begin failures++; $display("FAIL single_rd[%0d] got=%0d exp=%0d", i, rq[i], i); end
            checks++;
            if (wq[i] !== 10'(i) || aq[i] !== 1'b0) begin failures++; $display("FAIL single_wr[%0d] got=%0d_acc%b exp=%0d_acc0", i, wq[i], aq[i], i); end
            checks++;
        end
    endtask

    task automatic test_stall;
        run_job(8, 1, 0, 0, 0, 8, 3, 0, 0);
        for (int c = 8; c <= 10; c++) begin
            if (r_sys_en[c] !== 1'b0 || r_rd[c] !== 10'd3) begin failures++; $display("FAIL in_stall[%0d] got=en%b_rd%0d exp=en0_rd3", c, r_sys_en[c], r_rd[c]); end
            checks++;
        end
        if (r_sys_en[11] !== 1'b1 || r_rd[11] !== 10'd3) begin failures++; $display("FAIL in_resume got=en%b_rd%0d exp=en1_rd3", r_sys_en[11], r_rd[11]); end
        checks++;
        if (done_cyc !== 22 || wq.size() !== 8) begin failures++; $display("FAIL in_stall_done got=cyc%0d_wr%0d exp=cyc22_wr8", done_cyc, wq.size()); end
        checks++;
        run_job(8, 1, 0, 2, 2, 0, 0, 0, 0);
        if (done_cyc !== 21 || wt_pulses !== 4) begin failures++; $display("FAIL wt_stall_done got=cyc%0d_wt%0d exp=cyc21_wt4", done_cyc, wt_pulses); end
        checks++;
    endtask

    task automatic test_accum;
        run_job(8, 3, 1, 0, 0, 0, 0, 0, 0);
        if (done_cyc !== 55 || done_cnt !== 1 || wq.size() !== 24) begin failures++; $display("FAIL accum_job got=cyc%0d_cnt%0d_wr%0d exp=cyc55_cnt1_wr24", done_cyc, done_cnt, wq.size()); end
        checks++;
        for (int i = 0; i < 24; i++) begin
            if (wq[i] !== 10'(i % 8) || aq[i] !== (i >= 8) || tq[i] !== 5'(i / 8)) begin failures++; $display("FAIL accum_wr[%0d] got=%0d_acc%b_t%0d exp=%0d_acc%b_t%0d", i, wq[i], aq[i], tq[i], i % 8, i >= 8, i / 8); end
            checks++;
        end
    endtask

    task automatic test_separate;
        run_job(8, 2, 0, 0, 0, 0, 0, 0, 0);
        if (done_cyc !== 37 || wq.size() !== 16) begin failures++; $display("FAIL sep_job got=cyc%0d_wr%0d exp=cyc37_wr16", done_cyc, wq.size()); end
        checks++;
        for (int i = 0; i < 16; i++) begin
            if (wq[i] !== 10'(i) || aq[i] !== 1'b0 || tq[i] !== 5'(i / 8)) begin failures++; $display("FAIL sep_wr[%0d] got=%0d_acc%b_t%0d exp=%0d_acc0_t%0d", i, wq[i], aq[i], tq[i], i, i / 8); end
            checks++;
        end
    endtask

    task automatic test_abort;
        run_job(8, 2, 0, 0, 0, 0, 0, 28, 0);
        if (r_tile[28] !== 5'd1 || r_rd[28] !== 10'd5) begin failures++; $display("FAIL abort_pos got=t%0d_rd%0d exp=t1_rd5", r_tile[28], r_rd[28]); end
        checks++;
        if (end_cyc !== 29 || done_cnt !== 0 || r_tile[29] !== 5'd0) begin failures++; $display("FAIL abort_idle got=end%0d_done%0d_t%0d exp=end29_done0_t0", end_cyc, done_cnt, r_tile[29]); end
        checks++;
        if (wq.size() !== 8) begin failures++; $display("FAIL abort_writes got=%0d exp=8", wq.size()); end
        checks++;
    endtask

    task automatic test_start_ignored;
        run_job(8, 1, 0, 0, 0, 0, 0, 0, 10);
        if (done_cyc !== 19 || done_cnt !== 1 || wq.size() !== 8) begin failures++; $display("FAIL start_ignored got=cyc%0d_cnt%0d_wr%0d exp=cyc19_cnt1_wr8", done_cyc, done_cnt, wq.size()); end
        checks++;
    endtask

    task automatic test_back_to_back;
        run_job(8, 1, 0, 0, 0, 0, 0, 0, 0);
        run_job(3, 1, 0, 0, 0, 0, 0, 0, 0);
        if (done_cyc !== 14 || wq.size() !== 3 || wq[2] !== 10'd2) begin failures++; $display("FAIL back_to_back got=cyc%0d_wr%0d exp=cyc14_wr3", done_cyc, wq.size()); end
        checks++;
    endtask

    task automatic test_boundary;
        run_job(512, 1, 0, 0, 0, 0, 0, 0, 0);
        if (done_cyc !== 523 || wq.size() !== 512 || wq[511] !== 10'd511) begin failures++; $display("FAIL max_rows got=cyc%0d_wr%0d exp=cyc523_wr512", done_cyc, wq.size()); end
        checks++;
    endtask

    task automatic test_reset_midjob;
        cfg_rows = 10'd8; cfg_tiles = 5'd2; cfg_accum = 1'b0;
        start = 1'b1; wt_valid = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (24) @(posedge clk);
        @(negedge clk);
        if (busy !== 1'b1 || tile_idx !== 5'd1) begin failures++; $display("FAIL midjob_state got=busy%b_t%0d exp=busy1_t1", busy, tile_idx); end
        checks++;
        rst = 1'b1;
        #1;
        if (ready !== 1'b1 || tile_idx !== 5'd0 || wt_ready !== 1'b0) begin failures++; $display("FAIL async_reset got=ready%b_t%0d_wr%b exp=ready1_t0_wr0", ready, tile_idx, wt_ready); end
        checks++;
        @(negedge clk); rst = 1'b0;
        repeat (20) @(negedge clk);
        if (ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL reset_discard got=ready%b_done%b exp=ready1_done0", ready, done); end
        checks++;
        wt_valid = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_err;
        test_single;
        test_stall;
        test_accum;
        test_separate;
        test_abort;
        test_start_ignored;
        test_back_to_back;
        test_boundary;
        test_reset_midjob;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
